tdc_capture_decoder: RTL and testbench

// Receive side of the TDC delay line: launches the edge into the carry-chain line, samples its
// N-bit thermometer tap vector one clock later and decodes it to a binary code.

---
 rtl/tdc_capture_decoder_if.sv | 29 ++
 rtl/tdc_capture_decoder.sv | 173 +++++++++++++++++
 tb/tb_tdc_capture_decoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tdc_capture_decoder_if.sv
// tdc_capture_decoder_if
// Result port of the TDC capture decoder: valid/ready handshake carrying the
// decoded thermometer code and its quality flags.
//   meas_valid  : result valid (producer -> consumer)
//   meas_ready  : consumer accepts result (consumer -> producer)
//   meas_code   : number of ones in the captured taps
//   meas_ovf    : capture all ones
//   meas_unf    : capture all zeros
//   meas_bubble : capture not a clean thermometer
interface tdc_capture_decoder_if #(
  parameter int CW = 7
);
  logic          meas_valid;
  logic          meas_ready;
  logic [CW-1:0] meas_code;
  logic          meas_ovf;
  logic          meas_unf;
  logic          meas_bubble;

  modport master (
    output meas_valid, meas_code, meas_ovf, meas_unf, meas_bubble,
    input  meas_ready
  );

  modport slave (
    input  meas_valid, meas_code, meas_ovf, meas_unf, meas_bubble,
    output meas_ready
  );
endinterface

// File: rtl/tdc_capture_decoder.sv
// tdc_capture_decoder
// Receive side of a carry-chain TDC. Launches an edge into the delay line,
// captures the N-bit thermometer tap vector one clock later, decodes it to a
// ones count plus overflow/underflow/bubble flags, presents the result on a
// valid/ready port and then waits for the line to drain before re-arming.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : measurement request, sampled only in IDLE
//   launch      : registered edge into the delay-line input
//   dl_tap      : delay-line taps (asynchronous to clk, only ever registered)
//   busy        : high in every state except IDLE
//   err_stuck   : sticky, line failed to drain within RECOV_CYC cycles
//   meas        : result port (tdc_capture_decoder_if.master)
// Build option: define TDC_META_SYNC_EN to add a second capture flop plus a
// SYNC state (latency 3 instead of 2) and a 2-flop synchronizer on the drain
// sampling path.
module tdc_capture_decoder #(
  parameter int N         = 64,
  parameter int CW        = 7,
  parameter int RECOV_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   launch,
  input  logic [N-1:0]           dl_tap,
  output logic                   busy,
  output logic                   err_stuck,
  tdc_capture_decoder_if.master  meas
);

  localparam int RW = $clog2(RECOV_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SYNC, S_DECODE, S_HOLD, S_RECOVER
  } state_t;

  state_t          state_q;
  logic            launch_q, busy_q, valid_q, stuck_q;
  logic            ovf_q, unf_q, bub_q;
  logic [CW-1:0]   code_q;
  logic [N-1:0]    cap_q;
  logic [N-1:0]    samp_q;
  logic [N-1:0]    dec_src;
  logic [RW-1:0]   cnt_q;
  logic [CW-1:0]   dec_code;
  logic            dec_bub;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // A clean capture is exactly 'code' ones packed from bit 0 upward.
  function automatic logic not_thermo(input logic [N-1:0] v, input logic [CW-1:0] code);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N; i++)
      if (v[i] != (i < int'(code))) bad = 1'b1;
    return bad;
  endfunction

`ifdef TDC_META_SYNC_EN
  logic [N-1:0] cap2_q;
  logic [N-1:0] samp1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap2_q  <= '0;
      samp1_q <= '0;
      samp_q  <= '0;
    end else begin
      cap2_q  <= cap_q;
      samp1_q <= dl_tap;
      samp_q  <= samp1_q;
    end
  end

  assign dec_src = cap2_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_q <= '0;
    else        samp_q <= dl_tap;
  end

  assign dec_src = cap_q;
`endif

  assign dec_code = popcount(dec_src);
  assign dec_bub  = not_thermo(dec_src, dec_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      bub_q    <= 1'b0;
      code_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            launch_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        // The line integrates for exactly the one period launch is high.
        S_LAUNCH: begin
          cap_q    <= dl_tap;
          launch_q <= 1'b0;
`ifdef TDC_META_SYNC_EN
          state_q  <= S_SYNC;
`else
          state_q  <= S_DECODE;
`endif
        end
        S_SYNC: state_q <= S_DECODE;
        S_DECODE: begin
          code_q  <= dec_code;
          ovf_q   <= (dec_code == CW'(N));
          unf_q   <= (dec_code == '0);
          bub_q   <= dec_bub;
          valid_q <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (meas.meas_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (samp_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q == RW'(RECOV_CYC - 1)) begin
            stuck_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          launch_q <= 1'b0;
          busy_q   <= 1'b0;
          valid_q  <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign launch           = launch_q;
  assign busy             = busy_q;
  assign err_stuck        = stuck_q;
  assign meas.meas_valid  = valid_q;
  assign meas.meas_code   = code_q;
  assign meas.meas_ovf    = ovf_q;
  assign meas.meas_unf    = unf_q;
  assign meas.meas_bubble = bub_q;

endmodule

// File: tb/tb_tdc_capture_decoder.sv
module tb_tdc_capture_decoder;
  localparam int N         = 64;
  localparam int CW        = 7;
  localparam int RECOV_CYC = 16;
`ifdef TDC_META_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [CW-1:0] code;
    logic          ovf;
    logic          unf;
    logic          bub;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         launch;
  logic [N-1:0] dl_tap;
  logic         busy;
  logic         err_stuck;

  int pass_cnt = 0;
  int total    = 0;
  exp_t sb[$];

  tdc_capture_decoder_if #(.CW(CW)) mif ();

  tdc_capture_decoder #(.N(N), .CW(CW), .RECOV_CYC(RECOV_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .launch    (launch),
    .dl_tap    (dl_tap),
    .busy      (busy),
    .err_stuck (err_stuck),
    .meas      (mif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [N-1:0] p);
    exp_t m;
    m.code = CW'($countones(p));
    m.ovf  = (p == {N{1'b1}});
    m.unf  = (p == '0);
    m.bub  = ((p & (p + 64'd1)) != '0);
    return m;
  endfunction

  // One shot: pattern appears on the taps while launch is high; the line
  // drains after launch falls unless 'drain' is 0. hold = cycles of backpressure.
  task automatic run_meas(input logic [N-1:0] pat, input bit drain, input int hold);
    exp_t e;
    logic [CW-1:0] code0;
    int lat;
    int n;
    sb.push_back(model(pat));
    @(negedge clk);
    start      = 1'b1;
    mif.meas_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("launch_rise", launch, 1'b1);
    chk("busy_rise", busy, 1'b1);
    dl_tap = pat;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("launch_one_cycle", launch, 1'b0);
        if (drain) dl_tap = '0;
      end
      if (mif.meas_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, LAT);
    e = sb.pop_front();
    chk("code", mif.meas_code, e.code);
    chk("ovf", mif.meas_ovf, e.ovf);
    chk("unf", mif.meas_unf, e.unf);
    chk("bubble", mif.meas_bubble, e.bub);
    code0 = mif.meas_code;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      start = c[0];
      @(posedge clk); #1;
      chk("hold_valid", mif.meas_valid, 1'b1);
      chk("hold_code", mif.meas_code, code0);
    end
    @(negedge clk);
    start = 1'b0;
    mif.meas_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", mif.meas_valid, 1'b0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        n = c;
        break;
      end
    end
    chk("recover_cycles", n, drain ? 1 : RECOV_CYC);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    dl_tap = '0;
    mif.meas_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // T1: reset with start asserted
    chk("rst_launch", launch, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", mif.meas_valid, 1'b0);
    chk("rst_code", mif.meas_code, '0);
    chk("rst_flags", {mif.meas_ovf, mif.meas_unf, mif.meas_bubble}, 3'b000);
    chk("rst_stuck", err_stuck, 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_launch", launch, 1'b0);

    // T2: clean thermometer
    run_meas({{(N-23){1'b0}}, {23{1'b1}}}, 1'b1, 0);
    // T3: boundaries
    run_meas({N{1'b1}}, 1'b1, 0);
    run_meas('0, 1'b1, 0);
    run_meas(64'h0000_0000_0000_00F7, 1'b1, 0);
    run_meas({{(N-5){1'b0}}, 5'b10101}, 1'b1, 0);
    // T4: backpressure with stray start pulses
    run_meas({{(N-40){1'b0}}, {40{1'b1}}}, 1'b1, 10);
    chk("stuck_before", err_stuck, 1'b0);
    // T5: line never drains
    run_meas({{(N-9){1'b0}}, {9{1'b1}}}, 1'b0, 0);
    chk("stuck_set", err_stuck, 1'b1);
    @(negedge clk);
    dl_tap = '0;
    repeat (3) @(posedge clk);
    run_meas({{(N-31){1'b0}}, {31{1'b1}}}, 1'b1, 0);
    chk("stuck_sticky", err_stuck, 1'b1);

    // T6: async reset while holding a valid result
    @(negedge clk);
    start = 1'b1;
    mif.meas_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    dl_tap = {{(N-12){1'b0}}, {12{1'b1}}};
    @(posedge clk); #1;
    dl_tap = '0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("t6_hold_valid", mif.meas_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", mif.meas_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_launch", launch, 1'b0);
    chk("t6_stuck", err_stuck, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_meas({{(N-50){1'b0}}, {50{1'b1}}}, 1'b1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
